// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage of the RV32IM pipeline. Owns the PC,
// issues busywait-style reads to instruction memory and presents one
// registered instruction per cycle to IF/ID. A one-entry skid buffer absorbs
// the response that lands while IF/ID is stalled, and a DROP state lets an
// EX redirect arrive while a memory access is still in flight.
//
// Handshakes:
//   IF/ID side : the output slot {IF_INSTR, IF_PC} is offered while
//                IF_VALID=1 and is taken on any rising edge where STALL=0.
//                While STALL=1 the slot is held bit-stable.
//   IMEM side  : a request is IMEM_READ=1 with IMEM_ADDR; it completes on the
//                first rising edge where IMEM_BUSYWAIT=0, and IMEM_INSTR is
//                only meaningful on that edge. IMEM_ADDR never moves while
//                a request is outstanding and busy.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTR,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4,
    output logic        IF_VALID,
    output logic [1:0]  DBG_STATE
);

    // FETCH: access to PC outstanding; HOLD: skid full, no access issued;
    // DROP: redirect pending behind an access whose data will be discarded.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [31:0] branch_tgt;
    logic [31:0] pc_plus4;
    logic        slot_consumed;
    logic        slot_free;
    logic        unused_target_lsbs;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign branch_tgt         = {BRANCH_TARGET[31:2], 2'b00};
    assign unused_target_lsbs = &{1'b0, BRANCH_TARGET[1:0]};
    assign pc_plus4           = pc_q + 32'd4;
    assign slot_consumed      = out_valid_q & ~STALL;
    assign slot_free          = ~out_valid_q | slot_consumed;

    // Memory request: silent in HOLD and while reset is held.
    always_comb begin
        IMEM_READ = ~RESET & (state_q != ST_HOLD);
        IMEM_ADDR = pc_q;
    end

    // Output slot and debug view.
    always_comb begin
        IF_INSTR  = out_instr_q;
        IF_PC     = out_pc_q;
        IF_PC4    = out_pc_q + 32'd4;
        IF_VALID  = out_valid_q;
        DBG_STATE = state_q;
    end

    // Next-state logic; redirects always win over stalls.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_valid_d   = out_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        pend_target_d = pend_target_q;

        case (state_q)
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    out_valid_d = 1'b0;
                    if (!IMEM_BUSYWAIT) begin
                        // Response for the wrong path is simply not captured.
                        pc_d = branch_tgt;
                    end else begin
                        // Access cannot be cancelled; park the target.
                        pend_target_d = branch_tgt;
                        state_d       = ST_DROP;
                    end
                end else if (!IMEM_BUSYWAIT) begin
                    pc_d = pc_plus4;
                    if (slot_free) begin
                        out_instr_d = IMEM_INSTR;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                    end else begin
                        skid_instr_d = IMEM_INSTR;
                        skid_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (slot_consumed) begin
                    out_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    out_valid_d = 1'b0;
                    pc_d        = branch_tgt;
                    state_d     = ST_FETCH;
                end else if (!STALL) begin
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_FETCH;
                end
            end

            ST_DROP: begin
                out_valid_d = 1'b0;
                if (BRANCH_TAKEN) begin
                    pend_target_d = branch_tgt;
                end
                if (!IMEM_BUSYWAIT) begin
                    // Abandoned access finished; its data is thrown away.
                    pc_d    = BRANCH_TAKEN ? branch_tgt : pend_target_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            out_instr_q   <= 32'd0;
            out_pc_q      <= 32'd0;
            out_valid_q   <= 1'b0;
            skid_instr_q  <= 32'd0;
            skid_pc_q     <= 32'd0;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_valid_q   <= out_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule
